// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states, limits and helpers for the UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int MIN_PRESCALE = 8;
  localparam int DATA_W_MIN = 5;
  localparam int LEN_W = 4;
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input logic [LEN_W-1:0] max_len);
    return len < LEN_W'(DATA_W_MIN) ? LEN_W'(DATA_W_MIN) : len > max_len ? max_len : len;
  endfunction
endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: per-bit edge counter with 3-sample mid-bit majority vote.
module uart_rx_bit_timer #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  sample_o,
  output logic                  bit_o
);
  logic [PRESCALE_W-1:0] cnt_q, cnt_d, half;
  logic s0_q, s1_q;
  assign half = prescale_i >> 1;
  // While idle the counter parks at 1: the start-edge detection cycle is edge 0.
  assign cnt_d = !run_i ? PRESCALE_W'(1) : cnt_q == prescale_i - PRESCALE_W'(1) ? '0 : cnt_q + PRESCALE_W'(1);
  assign sample_o = run_i && cnt_q == half + PRESCALE_W'(1);
  assign bit_o = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (run_i && cnt_q == half - PRESCALE_W'(1)) s0_q <= rx_i;
      if (run_i && cnt_q == half) s1_q <= rx_i;
    end
  end
endmodule

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: configurable UART receiver with parity/framing/overrun flags
// and a valid/ready holding register for the received word.
module uart_rx_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  data_ready,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  ovr_err,
  output logic                  busy
);
  state_e state_q;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic par_en_q, par_typ_q, stop2_q, stop_idx_q, perr_q, serr_q;
  logic [LEN_W-1:0] len_q, bit_idx_q;
  logic [PRESCALE_W-1:0] ps_q;
  logic [DATA_W-1:0] shift_q, data_q;
  logic valid_q, par_err_q, stp_err_q, ovr_q;
  logic sample, rx_bit;

  uart_rx_bit_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q != IDLE),
    .rx_i      (rx_s2_q),
    .prescale_i(ps_q),
    .sample_o  (sample),
    .bit_o     (rx_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      len_q      <= '0;
      bit_idx_q  <= '0;
      ps_q       <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q   <= RX_IN;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      ovr_q     <= 1'b0;
      if (valid_q && data_ready) begin
        valid_q   <= 1'b0;
        par_err_q <= 1'b0;
        stp_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (rx_prev_q && !rx_s2_q) begin
          state_q    <= START;
          par_en_q   <= PAR_EN;
          par_typ_q  <= PAR_TYP;
          stop2_q    <= STOP2;
          len_q      <= clamp_len(DATA_LEN, LEN_W'(DATA_W));
          ps_q       <= prescale < PRESCALE_W'(MIN_PRESCALE) ? PRESCALE_W'(MIN_PRESCALE) : prescale;
          bit_idx_q  <= '0;
          shift_q    <= '0;
          stop_idx_q <= 1'b0;
          perr_q     <= 1'b0;
          serr_q     <= 1'b0;
        end
        START: if (sample) state_q <= rx_bit ? IDLE : DATA;
        DATA: if (sample) begin
          shift_q   <= {rx_bit, shift_q[DATA_W-1:1]};
          bit_idx_q <= bit_idx_q + LEN_W'(1);
          if (bit_idx_q == len_q - LEN_W'(1)) state_q <= par_en_q ? PARITY : STOP;
        end
        PARITY: if (sample) begin
          perr_q  <= ^shift_q ^ rx_bit ^ par_typ_q;
          state_q <= STOP;
        end
        STOP: if (sample) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_q <= 1'b1;
            serr_q     <= !rx_bit;
          end else begin
            state_q <= IDLE;
            // Bits were shifted in from the MSB; realign short words to the LSB.
            if (!valid_q || data_ready) begin
              data_q    <= shift_q >> (LEN_W'(DATA_W) - len_q);
              valid_q   <= 1'b1;
              par_err_q <= perr_q;
              stp_err_q <= serr_q | !rx_bit;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign P_DATA     = data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign ovr_err    = ovr_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: directed and randomized frames checked against a
// bit-level frame model of the UART line protocol.
module tb_uart_rx_gen2;
  localparam int DW = 8;
  localparam int PW = 6;
  logic clk = 1'b0, rst_n = 1'b0, RX_IN = 1'b1;
  logic PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0, data_ready = 1'b0;
  logic [3:0] DATA_LEN = 4'd8;
  logic [PW-1:0] prescale = 6'd8;
  logic [DW-1:0] P_DATA;
  logic data_valid, par_err, stp_err, ovr_err, busy;
  int checks = 0, errors = 0, ovr_cnt = 0;
  logic fb[$];

  uart_rx_gen2 #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .DATA_LEN(DATA_LEN), .prescale(prescale), .data_ready(data_ready),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .ovr_err(ovr_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ovr_err) ovr_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    step(n);
  endtask

  task automatic cfg(input logic pe, input logic pt, input logic s2, input logic [3:0] len, input logic [PW-1:0] ps);
    PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; DATA_LEN = len; prescale = ps;
  endtask

  // Line image of one frame: start, data LSB first, optional parity, stop bit(s).
  task automatic build(input int d, input int len, input logic pe, input logic pt, input logic corrupt,
                       input logic s2, input logic sv0, input logic sv1);
    int ones;
    logic [31:0] dv;
    dv = d;
    ones = 0;
    fb = {};
    fb.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      fb.push_back(dv[i]);
      ones += dv[i];
    end
    if (pe) fb.push_back(logic'(ones % 2) ^ pt ^ corrupt);
    fb.push_back(sv0);
    if (s2) fb.push_back(sv1);
  endtask

  task automatic play(input int ps, input logic scramble);
    for (int i = 0; i < fb.size(); i++) begin
      RX_IN = fb[i];
      step(ps);
      if (scramble && i == 0) begin
        PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
        DATA_LEN = 4'($urandom); prescale = PW'($urandom);
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!data_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, data_valid, 1);
    step(1);
  endtask

  task automatic check_word(input string tag, input int d, input logic pe, input logic se);
    chk({tag, "_data"}, P_DATA, d);
    chk({tag, "_par"}, par_err, pe);
    chk({tag, "_stp"}, stp_err, se);
  endtask

  task automatic consume(input string tag);
    data_ready = 1'b1;
    step(1);
    data_ready = 1'b0;
    chk({tag, "_valid_clr"}, data_valid, 0);
    chk({tag, "_flags_clr"}, {par_err, stp_err}, 0);
  endtask

  initial begin
    int ovr0, len_in, len, d, ps;
    logic pe, pt, corrupt, s2, sv0, sv1, exp_se;

    step(3);
    chk("reset_outputs", {P_DATA, data_valid, par_err, stp_err, ovr_err, busy}, 0);
    rst_n = 1'b1;
    idle(4);

    cfg(0, 0, 0, 8, 8);
    build(8'hA5, 8, 0, 0, 0, 0, 1, 1);
    play(8, 0);
    wait_valid("a5_valid");
    check_word("a5", 8'hA5, 0, 0);
    idle(10);
    chk("a5_hold_valid", data_valid, 1);
    chk("a5_hold_data", P_DATA, 8'hA5);
    consume("a5");

    cfg(1, 1, 1, 7, 8);
    build(8'h3C, 7, 1, 1, 1, 1, 1, 1);
    play(8, 0);
    wait_valid("7o2_valid");
    check_word("7o2", 8'h3C, 1, 0);
    consume("7o2");

    cfg(0, 0, 0, 8, 16);
    RX_IN = 1'b0;
    step(2);
    RX_IN = 1'b1;
    step(2);
    chk("glitch_busy_up", busy, 1);
    step(30);
    chk("glitch_busy_down", busy, 0);
    chk("glitch_no_valid", data_valid, 0);

    cfg(0, 0, 0, 8, 8);
    build(8'h96, 8, 0, 0, 0, 0, 0, 1);
    play(8, 0);
    idle(16);
    wait_valid("stp_valid");
    check_word("stp", 8'h96, 0, 1);
    consume("stp");
    build(8'h3E, 8, 0, 0, 0, 0, 1, 1);
    play(8, 0);
    wait_valid("after_stp_valid");
    check_word("after_stp", 8'h3E, 0, 0);
    consume("after_stp");

    ovr0 = ovr_cnt;
    build(8'h11, 8, 0, 0, 0, 0, 1, 1);
    play(8, 0);
    build(8'h22, 8, 0, 0, 0, 0, 1, 1);
    play(8, 0);
    idle(16);
    chk("ovr_valid", data_valid, 1);
    chk("ovr_data_kept", P_DATA, 8'h11);
    chk("ovr_pulses", ovr_cnt - ovr0, 1);
    consume("ovr");

    build(8'h77, 8, 0, 0, 0, 0, 1, 1);
    play(8, 0);
    wait_valid("pre_rst_valid");
    build(8'h0F, 8, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      RX_IN = fb[i];
      step(8);
    end
    RX_IN = fb[4];
    step(4);
    rst_n = 1'b0;
    RX_IN = 1'b1;
    #1;
    chk("midrst_outputs", {P_DATA, data_valid, par_err, stp_err, ovr_err, busy}, 0);
    step(2);
    rst_n = 1'b1;
    idle(60);
    chk("midrst_no_output", {data_valid, busy}, 0);
    build(8'h5A, 8, 0, 0, 0, 0, 1, 1);
    play(8, 0);
    wait_valid("after_rst_valid");
    check_word("after_rst", 8'h5A, 0, 0);
    consume("after_rst");

    ovr0 = ovr_cnt;
    for (int f = 0; f < 12; f++) begin
      len_in = $urandom_range(2, 12);
      len = len_in < 5 ? 5 : len_in > DW ? DW : len_in;
      d = int'($urandom) & ((1 << len) - 1);
      pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      corrupt = pe & 1'($urandom);
      sv0 = ($urandom % 4) != 0;
      sv1 = ($urandom % 4) != 0;
      exp_se = !sv0 || (s2 && !sv1);
      ps = 2 * $urandom_range(4, 10);
      cfg(pe, pt, s2, 4'(len_in), PW'(ps));
      build(d, len, pe, pt, corrupt, s2, sv0, sv1);
      play(ps, 1);
      idle(2 * ps);
      wait_valid("rand_valid");
      check_word("rand", d, corrupt, exp_se);
      consume("rand");
    end
    chk("rand_no_ovr", ovr_cnt - ovr0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_gen2.md
UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of prescale input.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port STOP2  input  1  two stop bits when 1, else one.
REQ-009 SHALL have port DATA_LEN  input  4  data bits per frame, 5..DATA_W.
REQ-010 SHALL have port prescale  input  PRESCALE_W  clk cycles per bit; legal values are even and >= 8.
REQ-011 SHALL have port data_ready  input  1  consumer accepts the held word.
REQ-012 SHALL have port P_DATA  output  DATA_W  received word, LSB-aligned.
REQ-013 SHALL have port data_valid  output  1  P_DATA holds an unconsumed word.
REQ-014 SHALL have port par_err  output  1  parity error of the held word.
REQ-015 SHALL have port stp_err  output  1  stop-bit (framing) error of the held word.
REQ-016 SHALL have port ovr_err  output  1  one-cycle pulse, frame dropped.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL pass RX_IN through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL leave IDLE for START on a synchronized falling edge, latching PAR_EN, PAR_TYP, STOP2, DATA_LEN and prescale; later changes to these inputs SHALL NOT affect the frame.
REQ-021 SHALL clamp a latched DATA_LEN below 5 to 5 and above DATA_W to DATA_W.
REQ-022 SHALL count edges 0..prescale-1 per bit and sample at edges prescale/2-1, prescale/2 and prescale/2+1, with bit value = 2-of-3 majority.
REQ-023 SHALL return START to IDLE with no output and no flag if the start-bit majority is 1 (glitch).
REQ-024 SHALL shift DATA bits LSB first and zero P_DATA bits at or above DATA_LEN.
REQ-025 SHALL enter PARITY after the last data bit only when PAR_EN is latched high, else STOP.
REQ-026 SHALL compute parity error as XOR(data bits, parity bit, PAR_TYP) = 1.
REQ-027 SHALL flag a stop error if any stop-bit majority is 0; with STOP2, both stop bits are checked.
REQ-028 SHALL complete the frame at the final stop-bit majority sample, go to IDLE on the next cycle, and accept a new falling edge immediately, without waiting for the remaining half-bit.
REQ-029 SHALL register the word, par_err and stp_err and assert data_valid one clk after frame completion.
REQ-030 SHALL hold P_DATA, par_err, stp_err and data_valid stable until a cycle with data_valid=1 and data_ready=1, then clear data_valid, par_err and stp_err on the next edge.
REQ-031 SHALL drop a completed frame, keep the held word unchanged and pulse ovr_err for one cycle if data_valid is still high without a same-cycle data_ready at completion; completion with a same-cycle handshake SHALL load the new word with no ovr_err.
REQ-032 SHALL deliver frames carrying par_err or stp_err like error-free frames.

Reset
REQ-033 SHALL, while rst_n=0, force state IDLE, counters 0, synchronizer flops 1, P_DATA 0, and data_valid, par_err, stp_err, ovr_err and busy 0.
REQ-034 SHALL abandon a frame in progress when reset asserts mid-frame, and SHALL produce no output for it after release.

Structure
REQ-035 SHALL take the state enum, MIN_PRESCALE=8, DATA_W_MIN=5 and the DATA_LEN width from shared package uart_rx_pkg.
REQ-036 SHALL place the edge/bit counter and the 3-sample majority voter in one sub-module, uart_rx_bit_timer.

Verification
REQ-037 SHALL check: prescale=8, 8N1, byte 0xA5 -> P_DATA=0xA5, data_valid high until data_ready, no error flags.
REQ-038 SHALL check: 7O2, DATA_LEN=7, data 0x3C with wrong parity bit -> P_DATA=0x3C, par_err=1, stp_err=0.
REQ-039 SHALL check: start low for 2 of 16 clks at prescale=16 -> busy returns to 0 and data_valid stays 0.
REQ-040 SHALL check: two back-to-back frames 0x11, 0x22 with data_ready=0 -> P_DATA stays 0x11 and ovr_err pulses exactly once.
REQ-041 SHALL check: 8N1 frame with stop bit 0 -> stp_err=1 with P_DATA delivered; next frame received correctly.
REQ-042 SHALL check: rst_n low at the 4th data bit -> all outputs 0; following 0x5A frame received correctly.
